// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF synchroniser, 3-sample majority vote, 5-9N/O/E 1/2 framing,
// per-word error tags and an FWFT FIFO (or single holding register) on an AXIS master port.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_rxd,
    input  logic                 i_m_axis_tready,
    output logic                 o_m_axis_tvalid,
    output logic [DATA_BITS-1:0] o_m_axis_tdata,
    output logic [1:0]           o_m_axis_tuser,
    output logic                 o_rxd_busy,
    output logic                 o_overrun,
    output logic [((FIFO_DEPTH == 0) ? 1 : $clog2(FIFO_DEPTH + 1))-1:0] o_fifo_level
);
    localparam int LVL_W = (FIFO_DEPTH == 0) ? 1 : $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int WORD_W = DATA_BITS + 2;
    localparam int M = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] SMP0     = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] SMP1     = CNT_W'(M);
    localparam logic [CNT_W-1:0] SMP2     = CNT_W'(M + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_WAIT_HI, S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state, state_nx;
    logic                 rxd_m, rxd_s;
    logic [1:0]           arm;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt, stop_last;
    logic                 s0, s1, vote, vote_now, busy;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr, perr;
    logic                 push_vld;
    logic [WORD_W-1:0]    push_word, rd_word;
    logic                 valid, ovr;
    logic [LVL_W-1:0]     level;

    // The synchroniser resets to idle-high, so the FSM must not trust rxd_s until
    // both stages have been loaded from the real line; arm tracks that.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            arm   <= 2'b00;
        end else begin
            rxd_m <= i_rxd;
            rxd_s <= rxd_m;
            arm   <= {arm[0], 1'b1};
        end
    end

    assign vote      = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
    assign vote_now  = busy && (cnt == SMP2);
    assign stop_last = (stop_cnt == LAST_STP);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state <= S_WAIT_HI;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT_HI: if (arm[1] && rxd_s) state_nx = S_IDLE;
            S_IDLE:    if (!rxd_s) state_nx = S_START;
            S_START:   if (vote_now) state_nx = vote ? S_IDLE : S_DATA;
            S_DATA:    if (vote_now && bit_cnt == LAST_BIT) state_nx = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:     if (vote_now) state_nx = S_STOP;
            S_STOP:    if (vote_now && stop_last) state_nx = (ferr || !vote) ? S_WAIT_HI : S_IDLE;
            default:   state_nx = S_WAIT_HI;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        case (state)
            S_START, S_DATA, S_PAR, S_STOP: busy = 1'b1;
            default:                        busy = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            shreg     <= '0;
            ferr      <= 1'b0;
            perr      <= 1'b0;
            push_vld  <= 1'b0;
            push_word <= '0;
        end else begin
            push_vld <= 1'b0;
            if (!busy) begin
                cnt      <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                ferr     <= 1'b0;
                perr     <= 1'b0;
            end else begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            if (cnt == SMP0) s0 <= rxd_s;
            if (cnt == SMP1) s1 <= rxd_s;
            if (vote_now) begin
                case (state)
                    S_DATA: begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    S_PAR: perr <= (PARITY == 1) ? ~(^shreg ^ vote) : (^shreg ^ vote);
                    S_STOP: begin
                        if (!vote) ferr <= 1'b1;
                        stop_cnt <= stop_cnt + 1'b1;
                        if (stop_last) begin
                            push_vld  <= 1'b1;
                            push_word <= {perr, ferr | ~vote, shreg};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    generate
        if (FIFO_DEPTH > 0) begin : g_fifo
            localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
            logic [WORD_W-1:0] mem [FIFO_DEPTH];
            logic [AW-1:0]     wr_ptr, rd_ptr;
            logic [LVL_W-1:0]  count;
            logic              full, pop, do_push;

            assign full    = (count == LVL_W'(FIFO_DEPTH));
            assign pop     = (count != '0) && i_m_axis_tready;
            // a pop in the same cycle frees the slot, so a full FIFO still accepts
            assign do_push = push_vld && (!full || pop);

            always_ff @(posedge i_clk) begin
                if (do_push) mem[wr_ptr] <= push_word;
            end

            always_ff @(posedge i_clk or posedge i_arst) begin
                if (i_arst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (do_push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop)     rd_ptr <= rd_ptr + 1'b1;
                    case ({do_push, pop})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                end
            end

            assign valid   = (count != '0);
            assign rd_word = valid ? mem[rd_ptr] : '0;
            assign level   = count;
            assign ovr     = push_vld && full && !pop;
        end else begin : g_reg
            logic              hold_vld, pop, do_push;
            logic [WORD_W-1:0] hold_word;

            assign pop     = hold_vld && i_m_axis_tready;
            assign do_push = push_vld && (!hold_vld || pop);

            always_ff @(posedge i_clk or posedge i_arst) begin
                if (i_arst) begin
                    hold_vld  <= 1'b0;
                    hold_word <= '0;
                end else if (do_push) begin
                    hold_vld  <= 1'b1;
                    hold_word <= push_word;
                end else if (pop) begin
                    hold_vld  <= 1'b0;
                end
            end

            assign valid   = hold_vld;
            assign rd_word = hold_vld ? hold_word : '0;
            assign level   = hold_vld;
            assign ovr     = push_vld && hold_vld && !pop;
        end
    endgenerate

    assign o_m_axis_tvalid = valid;
    assign o_m_axis_tdata  = rd_word[DATA_BITS-1:0];
    assign o_m_axis_tuser  = rd_word[WORD_W-1:DATA_BITS];
    assign o_rxd_busy      = busy;
    assign o_overrun       = ovr;
    assign o_fifo_level    = level;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance with a 4-deep FIFO and a 7E2 instance
// with the single holding register; expected words are queued when frames are sent.
module tb_uart_rx_cfg;
    localparam int CLKS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rxd_a = 1'b1, rdy_a = 1'b1, vld_a, busy_a, ovr_a;
    logic [7:0] dat_a;
    logic [1:0] usr_a;
    logic [2:0] lvl_a;

    logic       rxd_b = 1'b1, rdy_b = 1'b1, vld_b, busy_b, ovr_b;
    logic [6:0] dat_b;
    logic [1:0] usr_b;
    logic [0:0] lvl_b;

    uart_rx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .i_clk(clk), .i_arst(rst), .i_rxd(rxd_a), .i_m_axis_tready(rdy_a),
        .o_m_axis_tvalid(vld_a), .o_m_axis_tdata(dat_a), .o_m_axis_tuser(usr_a),
        .o_rxd_busy(busy_a), .o_overrun(ovr_a), .o_fifo_level(lvl_a));

    uart_rx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(0)) dut_b (
        .i_clk(clk), .i_arst(rst), .i_rxd(rxd_b), .i_m_axis_tready(rdy_b),
        .o_m_axis_tvalid(vld_b), .o_m_axis_tdata(dat_b), .o_m_axis_tuser(usr_b),
        .o_rxd_busy(busy_b), .o_overrun(ovr_b), .o_fifo_level(lvl_b));

    int checks = 0;
    int errors = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_b = 0;
    logic [9:0] q_a[$];
    logic [8:0] q_b[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitors: a pop happens at the next rising edge when tvalid && tready here
    always @(negedge clk) begin : mon_a
        logic [9:0] e;
        if (!rst) begin
            if (ovr_a) ovr_cnt_a++;
            if (vld_a && rdy_a) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL word_a unexpected got %h", {usr_a, dat_a});
                end else begin
                    e = q_a.pop_front();
                    if ({usr_a, dat_a} !== e) begin
                        errors++;
                        $display("FAIL word_a got %h expected %h", {usr_a, dat_a}, e);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [8:0] e;
        if (!rst) begin
            if (ovr_b) ovr_cnt_b++;
            if (vld_b && rdy_b) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL word_b unexpected got %h", {usr_b, dat_b});
                end else begin
                    e = q_b.pop_front();
                    if ({usr_b, dat_b} !== e) begin
                        errors++;
                        $display("FAIL word_b got %h expected %h", {usr_b, dat_b}, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) rxd_b = bits[i];
            else     rxd_a = bits[i];
            repeat (CLKS) tick();
        end
    endtask

    function automatic logic [15:0] f8(input logic [7:0] d, input logic stp);
        return {6'b0, stp, d, 1'b0};
    endfunction

    function automatic logic [15:0] f7e(input logic [6:0] d, input logic flip);
        return {5'b0, 2'b11, (^d) ^ flip, d, 1'b0};
    endfunction

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && (q_a.size() != 0 || q_b.size() != 0); i++) tick();
        chk(name, q_a.size() + q_b.size(), 0);
    endtask

    int seen, vseen, base;

    initial begin
        repeat (3) tick();
        chk("rst_tvalid_a", vld_a, 0);
        chk("rst_level_a", lvl_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_overrun_a", ovr_a, 0);
        chk("rst_tdata_a", {usr_a, dat_a}, 0);
        chk("rst_tvalid_b", vld_b, 0);
        rst = 1'b0;
        repeat (2 * CLKS) tick();

        // 8N1 back-to-back words
        q_a.push_back({2'b00, 8'hA5}); send(0, f8(8'hA5, 1'b1), 10);
        q_a.push_back({2'b00, 8'h3C}); send(0, f8(8'h3C, 1'b1), 10);
        drain("drain_8n1", 200);
        chk("level_8n1", lvl_a, 0);

        // 7E2: flipped parity, good parity, then holding-register overrun
        q_b.push_back({2'b10, 7'h55}); send(1, f7e(7'h55, 1'b1), 11);
        q_b.push_back({2'b00, 7'h55}); send(1, f7e(7'h55, 1'b0), 11);
        q_b.push_back({2'b00, 7'h23}); send(1, f7e(7'h23, 1'b0), 11);
        drain("drain_7e2", 200);
        rdy_b = 1'b0;
        q_b.push_back({2'b00, 7'h12}); send(1, f7e(7'h12, 1'b0), 11);
        send(1, f7e(7'h34, 1'b0), 11);
        repeat (4) tick();
        chk("overrun_reg", ovr_cnt_b, 1);
        chk("level_reg", lvl_b, 1);
        rdy_b = 1'b1;
        drain("drain_reg", 50);

        // break: one framing-error word, no start while the line stays low
        q_a.push_back({2'b01, 8'h00});
        rxd_a = 1'b0;
        repeat (12 * CLKS) tick();
        seen = 0;
        for (int i = 0; i < 8 * CLKS; i++) begin
            if (busy_a) seen = 1;
            tick();
        end
        chk("break_no_start", seen, 0);
        rxd_a = 1'b1;
        repeat (2 * CLKS) tick();
        q_a.push_back({2'b00, 8'h41}); send(0, f8(8'h41, 1'b1), 10);
        drain("drain_break", 200);

        // 6-clock glitch on idle line
        seen = 0; vseen = 0;
        rxd_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy_a) seen = 1;
            tick();
        end
        rxd_a = 1'b1;
        for (int i = 0; i < 3 * CLKS; i++) begin
            if (busy_a) seen = 1;
            if (vld_a) vseen = 1;
            tick();
        end
        chk("glitch_busy_pulse", seen, 1);
        chk("glitch_busy_end", busy_a, 0);
        chk("glitch_no_word", vseen, 0);

        // FIFO fill past full with tready low
        base = ovr_cnt_a;
        rdy_a = 1'b0;
        for (int d = 1; d <= 6; d++) begin
            if (d <= 4) q_a.push_back({2'b00, 8'(d)});
            send(0, f8(8'(d), 1'b1), 10);
        end
        repeat (4) tick();
        chk("overrun_fifo", ovr_cnt_a - base, 2);
        chk("level_full", lvl_a, 4);
        rdy_a = 1'b1;
        drain("drain_fifo", 50);
        chk("level_drained", lvl_a, 0);

        // reset mid-frame with buffered words, line low at release
        rdy_a = 1'b0;
        send(0, f8(8'h11, 1'b1), 10);
        send(0, f8(8'h22, 1'b1), 10);
        repeat (4) tick();
        chk("level_pre_reset", lvl_a, 2);
        send(0, f8(8'h7E, 1'b1), 2);
        rst = 1'b1;
        repeat (3) tick();
        chk("mid_rst_tvalid", vld_a, 0);
        chk("mid_rst_level", lvl_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_data", {usr_a, dat_a}, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 * CLKS; i++) begin
            if (busy_a || vld_a) seen = 1;
            tick();
        end
        rxd_a = 1'b1;
        for (int i = 0; i < 2 * CLKS; i++) begin
            if (busy_a || vld_a) seen = 1;
            tick();
        end
        chk("low_release_no_frame", seen, 0);
        rdy_a = 1'b1;
        q_a.push_back({2'b00, 8'h99}); send(0, f8(8'h99, 1'b1), 10);
        drain("drain_post_reset", 200);
        chk("level_final", lvl_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
